// File: rtl/counter_ctrl_pkg.sv
// Shared types and encodings for the counter sequencer and its counter core.
package counter_ctrl_pkg;

    localparam int unsigned DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [1:0] OP_START  = 2'd0;
    localparam logic [1:0] OP_STOP   = 2'd1;
    localparam logic [1:0] OP_PAUSE  = 2'd2;
    localparam logic [1:0] OP_RESUME = 2'd3;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/counter_ctrl_core.sv
// Plain WIDTH-bit counter register; clear takes priority over enable.
module counter_core #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             res,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] value
);

    always_ff @(posedge clk) begin
        if (res) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (en) begin
            value <= value + WIDTH'(1);
        end
    end

endmodule

// File: rtl/counter_ctrl.sv
// Command sequencer: gates/clears the counter core, detects the terminal value,
// and reports done pulses and completed periods.
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             res,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic             cmd_mode,
    input  logic [WIDTH-1:0] cmd_limit,
    output logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] periods
);

    state_t             state, state_d;
    logic [WIDTH-1:0]   limit_q, limit_d;
    logic               mode_q, mode_d;
    logic               done_d;
    logic [WIDTH-1:0]   periods_d;
    logic               core_en, core_clr;
    logic               accept, term;

    counter_core #(.WIDTH(WIDTH)) u_core (
        .clk   (clk),
        .res   (res),
        .en    (core_en),
        .clr   (core_clr),
        .value (value)
    );

    assign cmd_ready = ~res;
    assign busy      = (state != ST_IDLE);
    assign accept    = cmd_valid & cmd_ready;
    assign term      = (state == ST_RUN) && (value == limit_q);

    always_ff @(posedge clk) begin
        if (res) begin
            state   <= ST_IDLE;
            limit_q <= '1;
            mode_q  <= MODE_ONESHOT;
            done    <= 1'b0;
            periods <= '0;
        end else begin
            state   <= state_d;
            limit_q <= limit_d;
            mode_q  <= mode_d;
            done    <= done_d;
            periods <= periods_d;
        end
    end

    // START/STOP override the terminal event; PAUSE lets it apply first.
    always_comb begin
        state_d   = state;
        limit_d   = limit_q;
        mode_d    = mode_q;
        done_d    = 1'b0;
        periods_d = periods;
        core_en   = 1'b0;
        core_clr  = 1'b0;

        if (accept && cmd_op == OP_START) begin
            limit_d   = cmd_limit;
            mode_d    = cmd_mode;
            periods_d = '0;
            core_clr  = 1'b1;
            state_d   = ST_RUN;
        end else if (accept && cmd_op == OP_STOP) begin
            core_clr = 1'b1;
            state_d  = ST_IDLE;
        end else if (term) begin
            done_d = 1'b1;
            if (periods != '1) begin
                periods_d = periods + WIDTH'(1);
            end
            if (mode_q == MODE_PERIODIC) begin
                core_clr = 1'b1;
                state_d  = (accept && cmd_op == OP_PAUSE) ? ST_PAUSE : ST_RUN;
            end else begin
                state_d = ST_IDLE;
            end
        end else if (state == ST_RUN) begin
            if (accept && cmd_op == OP_PAUSE) begin
                state_d = ST_PAUSE;
            end else begin
                core_en = 1'b1;
            end
        end else if (state == ST_PAUSE && accept && cmd_op == OP_RESUME) begin
            state_d = ST_RUN;
        end
    end

endmodule
